// File: rtl/text_console_writer.sv
// Character-stream to text-memory writer with cursor handling, line wrap, and hardware line/screen clear.
// Define CONSOLE_SCROLL_EN to scroll at the bottom row; otherwise the cursor wraps to row 0.
module text_console_writer #(
  parameter int          COLS       = 160,
  parameter int          ROWS       = 45,
  parameter logic [7:0]  CLEAR_ATTR = 8'h0F
) (
  input  logic        clk_hdmi_in,
  input  logic        rst_in,
  input  logic        char_valid_in,
  input  logic [7:0]  char_in,
  input  logic [7:0]  attribute_in,
  output logic        char_ready_out,
  input  logic        clear_in,
  output logic        wr_en_out,
  output logic [12:0] wr_addr_out,
  output logic [7:0]  wr_code_point_out,
  output logic [7:0]  wr_attribute_out,
  output logic [7:0]  cursor_x_out,
  output logic [5:0]  cursor_y_out,
  output logic [5:0]  scroll_row_out,
  output logic        busy_out
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_LINE,
    CLEAR_SCREEN
  } state_t;

  localparam logic [7:0]  CH_BS     = 8'h08;
  localparam logic [7:0]  CH_LF     = 8'h0A;
  localparam logic [7:0]  CH_CR     = 8'h0D;
  localparam logic [7:0]  CH_SPACE  = 8'h20;
  localparam logic [7:0]  LAST_COL  = 8'(COLS - 1);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
  localparam logic [6:0]  ROWS_W    = 7'(ROWS);
  localparam logic [12:0] COLS_A    = 13'(COLS);
  localparam logic [12:0] LAST_ADDR = 13'(ROWS * COLS - 1);

  state_t      state;
  logic [7:0]  cur_x;
  logic [5:0]  cur_y;
  logic [5:0]  scroll_row;
  logic [7:0]  clr_col;
  logic [12:0] clr_addr;

  logic        transfer;
  logic        line_adv;
  logic [6:0]  row_sum;
  logic [5:0]  phys_row;
  logic [12:0] cell_addr;

  // Ready is gated by reset so it reads 0 for the whole time reset is held.
  assign char_ready_out = rst_in & (state == IDLE) & ~clear_in;
  assign transfer       = char_valid_in & char_ready_out;
  assign busy_out       = (state != IDLE);
  assign cursor_x_out   = cur_x;
  assign cursor_y_out   = cur_y;

`ifdef CONSOLE_SCROLL_EN
  assign scroll_row_out = scroll_row;
`else
  assign scroll_row_out = 6'd0;
`endif

  // Logical row to physical row: (scroll_row + cur_y) mod ROWS; the sum is below 2*ROWS.
  assign row_sum   = {1'b0, scroll_row} + {1'b0, cur_y};
  assign phys_row  = (row_sum >= ROWS_W) ? 6'(row_sum - ROWS_W) : row_sum[5:0];
  assign cell_addr = 13'(phys_row) * COLS_A + 13'(cur_x);

  // A line advance comes from LF or from a printable character written in the last column.
  assign line_adv = (char_in == CH_LF) ||
                    ((char_in != CH_BS) && (char_in != CH_CR) && (cur_x == LAST_COL));

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order in this block.
  always_ff @(posedge clk_hdmi_in or negedge rst_in) begin
    if (!rst_in) begin
      state             <= IDLE;
      cur_x             <= '0;
      cur_y             <= '0;
      scroll_row        <= '0;
      clr_col           <= '0;
      clr_addr          <= '0;
      wr_en_out         <= 1'b0;
      wr_addr_out       <= '0;
      wr_code_point_out <= '0;
      wr_attribute_out  <= '0;
    end else begin
      wr_en_out <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_in) begin
            state    <= CLEAR_SCREEN;
            clr_addr <= '0;
          end else if (transfer) begin
            if (char_in == CH_BS) begin
              if (cur_x != 8'd0) cur_x <= cur_x - 8'd1;
            end else if (char_in == CH_CR) begin
              cur_x <= '0;
            end else begin
              if (char_in != CH_LF) begin
                wr_en_out         <= 1'b1;
                wr_addr_out       <= cell_addr;
                wr_code_point_out <= char_in;
                wr_attribute_out  <= attribute_in;
              end
              if (line_adv) begin
                cur_x <= '0;
                if (cur_y != LAST_ROW) begin
                  cur_y <= cur_y + 6'd1;
                end else begin
                  state   <= CLEAR_LINE;
                  clr_col <= '0;
`ifdef CONSOLE_SCROLL_EN
                  // The old top physical row becomes the new bottom row.
                  scroll_row <= (scroll_row == LAST_ROW) ? 6'd0 : scroll_row + 6'd1;
                  clr_addr   <= 13'(scroll_row) * COLS_A;
`else
                  cur_y    <= '0;
                  clr_addr <= '0;
`endif
                end
              end else begin
                cur_x <= cur_x + 8'd1;
              end
            end
          end
        end

        CLEAR_LINE: begin
          wr_en_out         <= 1'b1;
          wr_addr_out       <= clr_addr;
          wr_code_point_out <= CH_SPACE;
          wr_attribute_out  <= CLEAR_ATTR;
          clr_addr          <= clr_addr + 13'd1;
          if (clr_col == LAST_COL) state <= IDLE;
          else                     clr_col <= clr_col + 8'd1;
        end

        CLEAR_SCREEN: begin
          wr_en_out         <= 1'b1;
          wr_addr_out       <= clr_addr;
          wr_code_point_out <= CH_SPACE;
          wr_attribute_out  <= CLEAR_ATTR;
          clr_addr          <= clr_addr + 13'd1;
          if (clr_addr == LAST_ADDR) begin
            state      <= IDLE;
            cur_x      <= '0;
            cur_y      <= '0;
            scroll_row <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer: writes, control codes, bottom-row
// line clear (both build flavours), full-screen clear priority, and reset abort.
module tb_text_console_writer;

  logic        clk_hdmi_in = 1'b0;
  logic        rst_in;
  logic        char_valid_in;
  logic [7:0]  char_in;
  logic [7:0]  attribute_in;
  logic        char_ready_out;
  logic        clear_in;
  logic        wr_en_out;
  logic [12:0] wr_addr_out;
  logic [7:0]  wr_code_point_out;
  logic [7:0]  wr_attribute_out;
  logic [7:0]  cursor_x_out;
  logic [5:0]  cursor_y_out;
  logic [5:0]  scroll_row_out;
  logic        busy_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [12:0] log_addr[$];
  logic [7:0]  log_code[$];
  logic [7:0]  log_attr[$];

  text_console_writer dut (
    .clk_hdmi_in       (clk_hdmi_in),
    .rst_in            (rst_in),
    .char_valid_in     (char_valid_in),
    .char_in           (char_in),
    .attribute_in      (attribute_in),
    .char_ready_out    (char_ready_out),
    .clear_in          (clear_in),
    .wr_en_out         (wr_en_out),
    .wr_addr_out       (wr_addr_out),
    .wr_code_point_out (wr_code_point_out),
    .wr_attribute_out  (wr_attribute_out),
    .cursor_x_out      (cursor_x_out),
    .cursor_y_out      (cursor_y_out),
    .scroll_row_out    (scroll_row_out),
    .busy_out          (busy_out)
  );

  always #5 clk_hdmi_in = ~clk_hdmi_in;

  // Write monitor: every strobe seen mid-cycle goes into the log.
  always @(negedge clk_hdmi_in) begin
    if (wr_en_out === 1'b1) begin
      log_addr.push_back(wr_addr_out);
      log_code.push_back(wr_code_point_out);
      log_attr.push_back(wr_attribute_out);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_code.delete();
    log_attr.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_hdmi_in);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int waited = 0;
    char_valid_in = 1'b1;
    char_in       = c;
    attribute_in  = a;
    @(negedge clk_hdmi_in);
    while (char_ready_out !== 1'b1 && waited < 10000) begin
      waited++;
      @(negedge clk_hdmi_in);
    end
    if (waited >= 10000) check("send_ready_timeout", {31'b0, char_ready_out}, 32'd1);
    @(posedge clk_hdmi_in);
    #1 char_valid_in = 1'b0;
  endtask

  task automatic check_cursor(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(cursor_x_out), 32'(x));
    check({tag, "_y"}, 32'(cursor_y_out), 32'(y));
  endtask

  // Counts log entries that are not a space/0x0F clear of address base+i, for i in [0, n).
  function automatic int bad_clear_entries(input int base, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= log_addr.size()) bad++;
      else if (log_addr[i] != 13'(base + i) || log_code[i] != 8'h20 || log_attr[i] != 8'h0F) bad++;
    end
    return bad;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    int rdy_hi;
    int cyc;
    rst_in        = 1'b0;
    char_valid_in = 1'b0;
    char_in       = 8'h00;
    attribute_in  = 8'h00;
    clear_in      = 1'b0;

    // Reset state
    idle(3);
    check("rst_wr_en", {31'b0, wr_en_out}, 32'd0);
    check("rst_wr_addr", 32'(wr_addr_out), 32'd0);
    check("rst_wr_code", 32'(wr_code_point_out), 32'd0);
    check("rst_wr_attr", 32'(wr_attribute_out), 32'd0);
    check("rst_busy", {31'b0, busy_out}, 32'd0);
    check("rst_ready", {31'b0, char_ready_out}, 32'd0);
    check("rst_scroll", 32'(scroll_row_out), 32'd0);
    check_cursor("rst_cursor", 0, 0);
    rst_in = 1'b1;
    idle(2);

    // Single printable character, latency 1, exactly one strobe
    clear_log();
    send(8'h41, 8'h1E);
    @(negedge clk_hdmi_in);
    check("a_wr_en", {31'b0, wr_en_out}, 32'd1);
    check("a_wr_addr", 32'(wr_addr_out), 32'd0);
    check("a_wr_code", 32'(wr_code_point_out), 32'h41);
    check("a_wr_attr", 32'(wr_attribute_out), 32'h1E);
    check_cursor("a_cursor", 1, 0);
    @(negedge clk_hdmi_in);
    check("a_single_strobe", {31'b0, wr_en_out}, 32'd0);
    idle(1);

    // Full row of 160 characters wraps to the next line
    send(8'h0D, 8'h00);
    check_cursor("cr_home", 0, 0);
    clear_log();
    for (int i = 0; i < 160; i++) send(8'h41 + 8'(i % 26), 8'h07);
    idle(3);
    check("row_writes", 32'(log_addr.size()), 32'd160);
    check("row_first_addr", 32'(log_addr[0]), 32'd0);
    check("row_last_addr", 32'(log_addr[159]), 32'd159);
    check("row_last_code", 32'(log_code[159]), 32'h44);
    check_cursor("row_wrap", 0, 1);

    // Control codes: BS, CR, LF, and BS at column 0
    send(8'h0A, 8'h00);
    send(8'h0A, 8'h00);
    for (int i = 0; i < 5; i++) send(8'h78, 8'h07);
    check_cursor("pos_5_3", 5, 3);
    idle(2);
    clear_log();
    send(8'h08, 8'h00);
    check_cursor("bs", 4, 3);
    send(8'h0D, 8'h00);
    check_cursor("cr", 0, 3);
    send(8'h0A, 8'h00);
    check_cursor("lf", 0, 4);
    send(8'h08, 8'h00);
    check_cursor("bs_col0", 0, 4);
    idle(3);
    check("ctrl_no_writes", 32'(log_addr.size()), 32'd0);

    // Line advance below the bottom row
    for (int i = 0; i < 40; i++) send(8'h0A, 8'h00);
    check_cursor("bottom_row", 0, 44);
    clear_log();
    send(8'h0A, 8'h00);
    rdy_hi = 0;
    repeat (160) begin
      @(negedge clk_hdmi_in);
      if (char_ready_out !== 1'b0) rdy_hi++;
    end
    cyc = 0;
    while (busy_out !== 1'b0 && cyc < 1000) begin
      cyc++;
      @(negedge clk_hdmi_in);
    end
    check("cl_busy_end", {31'b0, busy_out}, 32'd0);
    idle(3);
    check("cl_ready_low", 32'(rdy_hi), 32'd0);
    check("cl_writes", 32'(log_addr.size()), 32'd160);
    check("cl_bad_entries", 32'(bad_clear_entries(0, 160)), 32'd0);
`ifdef CONSOLE_SCROLL_EN
    check("cl_scroll", 32'(scroll_row_out), 32'd1);
    check_cursor("cl_cursor", 0, 44);
`else
    check("cl_scroll", 32'(scroll_row_out), 32'd0);
    check_cursor("cl_cursor", 0, 0);
`endif
    // Logical bottom/top row now maps to physical row 0 in both flavours
    clear_log();
    send(8'h5A, 8'h07);
    idle(2);
    check("after_cl_addr", 32'(log_addr[0]), 32'd0);
    check("after_cl_code", 32'(log_code[0]), 32'h5A);

    // Clear screen has priority over a simultaneous character
    clear_log();
    clear_in      = 1'b1;
    char_valid_in = 1'b1;
    char_in       = 8'h51;
    attribute_in  = 8'h55;
    @(negedge clk_hdmi_in);
    check("cs_ready_low", {31'b0, char_ready_out}, 32'd0);
    @(posedge clk_hdmi_in);
    #1 clear_in = 1'b0;
    @(negedge clk_hdmi_in);
    check("cs_busy", {31'b0, busy_out}, 32'd1);
    cyc = 0;
    while (busy_out !== 1'b0 && cyc < 8000) begin
      cyc++;
      @(negedge clk_hdmi_in);
    end
    check("cs_busy_end", {31'b0, busy_out}, 32'd0);
    check_cursor("cs_cursor", 0, 0);
    check("cs_scroll", 32'(scroll_row_out), 32'd0);
    check("cs_ready_after", {31'b0, char_ready_out}, 32'd1);
    @(posedge clk_hdmi_in);
    #1 char_valid_in = 1'b0;
    idle(3);
    check("cs_writes", 32'(log_addr.size()), 32'd7201);
    check("cs_bad_entries", 32'(bad_clear_entries(0, 7200)), 32'd0);
    check("cs_char_addr", 32'(log_addr[7200]), 32'd0);
    check("cs_char_code", 32'(log_code[7200]), 32'h51);
    check("cs_char_attr", 32'(log_attr[7200]), 32'h55);
    check_cursor("cs_char_cursor", 1, 0);

    // Reset during the 100th cycle of a screen clear
    clear_in = 1'b1;
    @(posedge clk_hdmi_in);
    #1 clear_in = 1'b0;
    repeat (99) @(posedge clk_hdmi_in);
    #2;
    check("abort_wr_en_before", {31'b0, wr_en_out}, 32'd1);
    rst_in = 1'b0;
    #1;
    check("abort_wr_en", {31'b0, wr_en_out}, 32'd0);
    check("abort_busy", {31'b0, busy_out}, 32'd0);
    check("abort_wr_addr", 32'(wr_addr_out), 32'd0);
    @(posedge clk_hdmi_in);
    #1 rst_in = 1'b1;
    clear_log();
    idle(300);
    check("abort_no_writes", 32'(log_addr.size()), 32'd0);
    check("abort_idle", {31'b0, busy_out}, 32'd0);
    check_cursor("abort_cursor", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
